// File: rtl/ram_port_ctrl_if.sv
// Request/response channel between the load/store path and ram_port_ctrl.
// master = requester, slave = controller.
interface ram_port_ctrl_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [AW-1:0] req_len;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_last;
  logic          rsp_is_write;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_is_write
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_is_write
  );
endinterface

// File: rtl/ram_port_ctrl.sv
// Initiator for the 16x8 Ram: single-beat writes with an isolated write strobe,
// burst reads with address wrap, valid/ready request and response channels.
module ram_port_ctrl #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  ram_port_ctrl_if.slave bus,
  output logic [AW-1:0] ram_addr_read,
  output logic          ram_read_enable,
  input  logic [DW-1:0] ram_data_out,
  output logic [DW-1:0] ram_data_in,
  output logic [AW-1:0] ram_addr_write,
  output logic          ram_write_enable
);

  typedef enum logic [2:0] {
    IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WR_ACK, RD_ISSUE, RD_RSP
  } state_e;

  localparam logic [AW-1:0] ONE = AW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] beat_q, beat_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_last_q, rsp_last_d;
  logic          rsp_is_write_q, rsp_is_write_d;
  logic          ram_re_q, ram_re_d;
  logic [AW-1:0] ram_addr_read_q, ram_addr_read_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_write_q, ram_addr_write_d;
  logic [DW-1:0] ram_data_in_q, ram_data_in_d;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    beat_d           = beat_q;
    rsp_valid_d      = rsp_valid_q;
    rsp_rdata_d      = rsp_rdata_q;
    rsp_last_d       = rsp_last_q;
    rsp_is_write_d   = rsp_is_write_q;
    ram_re_d         = 1'b0;
    ram_addr_read_d  = ram_addr_read_q;
    ram_we_d         = 1'b0;
    ram_addr_write_d = ram_addr_write_q;
    ram_data_in_d    = ram_data_in_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          len_d  = bus.req_len;
          beat_d = '0;
          if (bus.req_we) begin
            state_d          = WR_SETUP;
            ram_addr_write_d = bus.req_addr;
            ram_data_in_d    = bus.req_wdata;
          end else begin
            state_d         = RD_ISSUE;
            ram_re_d        = 1'b1;
            ram_addr_read_d = bus.req_addr;
          end
        end
      end
      WR_SETUP: begin
        state_d  = WR_STROBE;
        ram_we_d = 1'b1;
      end
      WR_STROBE: state_d = WR_HOLD;
      WR_HOLD: begin
        state_d        = WR_ACK;
        rsp_valid_d    = 1'b1;
        rsp_is_write_d = 1'b1;
        rsp_last_d     = 1'b1;
        rsp_rdata_d    = '0;
      end
      WR_ACK: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      RD_ISSUE: begin
        state_d        = RD_RSP;
        rsp_rdata_d    = ram_data_out;
        rsp_valid_d    = 1'b1;
        rsp_is_write_d = 1'b0;
        rsp_last_d     = (beat_q == len_q);
      end
      RD_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (rsp_last_q) begin
            state_d = IDLE;
          end else begin
            // next beat: AW-bit address wraps naturally
            addr_d          = addr_q + ONE;
            beat_d          = beat_q + ONE;
            ram_addr_read_d = addr_q + ONE;
            ram_re_d        = 1'b1;
            state_d         = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      addr_q           <= '0;
      len_q            <= '0;
      beat_q           <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_rdata_q      <= '0;
      rsp_last_q       <= 1'b0;
      rsp_is_write_q   <= 1'b0;
      ram_re_q         <= 1'b0;
      ram_addr_read_q  <= '0;
      ram_we_q         <= 1'b0;
      ram_addr_write_q <= '0;
      ram_data_in_q    <= '0;
    end else begin
      state_q          <= state_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      beat_q           <= beat_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_rdata_q      <= rsp_rdata_d;
      rsp_last_q       <= rsp_last_d;
      rsp_is_write_q   <= rsp_is_write_d;
      ram_re_q         <= ram_re_d;
      ram_addr_read_q  <= ram_addr_read_d;
      ram_we_q         <= ram_we_d;
      ram_addr_write_q <= ram_addr_write_d;
      ram_data_in_q    <= ram_data_in_d;
    end
  end

  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.rsp_is_write = rsp_is_write_q;
  assign ram_addr_read    = ram_addr_read_q;
  assign ram_read_enable  = ram_re_q;
  assign ram_data_in      = ram_data_in_q;
  assign ram_addr_write   = ram_addr_write_q;
  assign ram_write_enable = ram_we_q;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Bench for ram_port_ctrl: behavioural RAM, edge-indexed transaction model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ram_port_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ram_addr_read;
  logic       ram_read_enable;
  logic [7:0] ram_data_out;
  logic [7:0] ram_data_in;
  logic [3:0] ram_addr_write;
  logic       ram_write_enable;

  ram_port_ctrl_if #(.AW(4), .DW(8)) bus ();

  ram_port_ctrl #(.AW(4), .DW(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .ram_addr_read    (ram_addr_read),
    .ram_read_enable  (ram_read_enable),
    .ram_data_out     (ram_data_out),
    .ram_data_in      (ram_data_in),
    .ram_addr_write   (ram_addr_write),
    .ram_write_enable (ram_write_enable)
  );

  always #5 clk = ~clk;

  // Ram block: combinational read, write on rising edge of write_enable
  logic [7:0] mem [16];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    forever begin
      @(posedge ram_write_enable);
      mem[ram_addr_write] = ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_addr_read];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // model state (edge indices: the edge at which something happens)
  logic [7:0] model_mem [16];
  logic       armed = 1'b0, busy = 1'b0;
  int         wr_at = -1, issue_at = -1, rsp_at = -1, reset_at = -1;
  logic [3:0] w_addr, rd_addr, rd_len, beat;
  logic [7:0] w_data, e_rdata;
  logic       e_last, e_isw, prev_we = 1'b0, exp_v;
  int         we_count = 0, we_rise_cyc = -1, stall_cnt = 0;
  int         acc_edges[$], hs_edges[$];
  logic [7:0] got_data[$];
  logic       got_last[$], got_isw[$];

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
    forever begin
      @(negedge clk);
      if (ram_write_enable === 1'b1 && !prev_we) begin
        we_count++;
        we_rise_cyc = cyc;
      end
      prev_we = (ram_write_enable === 1'b1);
      exp_v = (rsp_at >= 0) && (cyc >= rsp_at);
      if (armed) begin
        if (reset_at == cyc)
          check("reset_outputs", {bus.rsp_valid, bus.rsp_rdata, bus.rsp_last, bus.rsp_is_write,
                ram_read_enable, ram_write_enable, ram_addr_read, ram_addr_write, ram_data_in}, 32'h0);
        check("req_ready", bus.req_ready, !busy);
        check("write_enable", ram_write_enable, (wr_at >= 0) && (cyc == wr_at + 1));
        if (wr_at >= 0 && cyc >= wr_at && cyc <= wr_at + 3)
          check("write_addr_data", {ram_addr_write, ram_data_in}, {w_addr, w_data});
        check("read_enable", ram_read_enable, issue_at == cyc);
        if (issue_at == cyc) check("read_addr", ram_addr_read, rd_addr);
        check("rsp_valid", bus.rsp_valid, exp_v);
        if (exp_v) begin
          check("rsp_rdata", bus.rsp_rdata, e_rdata);
          check("rsp_last", bus.rsp_last, e_last);
          check("rsp_is_write", bus.rsp_is_write, e_isw);
          if (!bus.rsp_ready) stall_cnt++;
        end
      end
      if (!rst_n) begin
        armed = 1'b1; busy = 1'b0;
        wr_at = -1; issue_at = -1; rsp_at = -1;
        reset_at = cyc + 1;
      end else if (armed) begin
        if (!busy && bus.req_valid) begin
          busy = 1'b1;
          acc_edges.push_back(cyc + 1);
          if (bus.req_we) begin
            wr_at = cyc + 1; w_addr = bus.req_addr; w_data = bus.req_wdata;
            rsp_at = cyc + 4; e_rdata = 8'h00; e_last = 1'b1; e_isw = 1'b1;
          end else begin
            rd_addr = bus.req_addr; rd_len = bus.req_len; beat = 4'd0;
            issue_at = cyc + 1; rsp_at = cyc + 2;
            e_rdata = model_mem[bus.req_addr]; e_last = (bus.req_len == 4'd0); e_isw = 1'b0;
          end
        end else if (exp_v && bus.rsp_ready) begin
          hs_edges.push_back(cyc + 1);
          got_data.push_back(bus.rsp_rdata);
          got_last.push_back(bus.rsp_last);
          got_isw.push_back(bus.rsp_is_write);
          rsp_at = -1;
          if (e_isw) begin
            model_mem[w_addr] = w_data;
            busy = 1'b0;
          end else if (e_last) begin
            busy = 1'b0;
          end else begin
            rd_addr = rd_addr + 4'd1; beat = beat + 4'd1;
            issue_at = cyc + 1; rsp_at = cyc + 2;
            e_rdata = model_mem[rd_addr]; e_last = (beat == rd_len);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d, input logic [3:0] l);
    logic ok;
    ok = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d; bus.req_len = l;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    check("accept_in_time", ok, 1'b1);
  endtask

  task automatic wait_rsp(input int n);
    for (int i = 0; i < 300 && got_data.size() < n; i++) tick();
    check("rsp_in_time", got_data.size() >= n, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, a, w0;
    rst_n = 1'b0; bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5;
    bus.req_wdata = 8'h77; bus.req_len = 4'd0;
    repeat (3) tick();
    rst_n = 1'b1; bus.req_valid = 1'b0;
    @(negedge clk);
    check("ready_after_reset", bus.req_ready, 1'b1);
    check("no_accept_in_reset", acc_edges.size(), 0);
    check("no_write_in_reset", we_count, 0);
    tick();

    // write A5 to 3, then single-beat read
    send(1'b1, 4'd3, 8'hA5, 4'd0);
    wait_rsp(1);
    check("wr_ack_is_write", got_isw[0], 1'b1);
    check("wr_ack_rdata", got_data[0], 8'h00);
    check("we_pulse_count", we_count, 1);
    check("we_offset", we_rise_cyc - acc_edges[0], 1);
    check("wr_ack_latency", hs_edges[0] - acc_edges[0], 4);
    send(1'b0, 4'd3, 8'h00, 4'd0);
    wait_rsp(2);
    check("rd_data_a5", got_data[1], 8'hA5);
    check("rd_last", got_last[1], 1'b1);
    check("rd_latency", hs_edges[1] - acc_edges[1], 2);

    for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 8'(i + 16), 4'd0);
    wait_rsp(18);

    // wrap burst from 14, stall beat 2
    b = got_data.size();
    stall_cnt = 0;
    send(1'b0, 4'd14, 8'h00, 4'd3);
    wait_rsp(b + 1);
    bus.rsp_ready = 1'b0;
    repeat (6) tick();
    bus.rsp_ready = 1'b1;
    wait_rsp(b + 4);
    check("burst_b0", got_data[b],     8'h1E);
    check("burst_b1", got_data[b + 1], 8'h1F);
    check("burst_b2", got_data[b + 2], 8'h10);
    check("burst_b3", got_data[b + 3], 8'h11);
    check("burst_last", {got_last[b], got_last[b + 1], got_last[b + 2], got_last[b + 3]}, 4'b0001);
    check("stall_cycles", stall_cnt >= 4, 1'b1);

    // reset landing on the WR_SETUP -> WR_STROBE edge
    w0 = we_count; b = got_data.size();
    send(1'b1, 4'd7, 8'hEE, 4'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("abort_no_strobe", we_count, w0);
    check("abort_no_rsp", got_data.size(), b);
    send(1'b0, 4'd7, 8'h00, 4'd0);
    wait_rsp(b + 1);
    check("abort_mem_unchanged", got_data[b], 8'h17);

    // back-to-back write then read with req_valid held
    a = acc_edges.size(); b = got_data.size();
    send(1'b1, 4'd0, 8'h3C, 4'd0);
    send(1'b0, 4'd0, 8'h00, 4'd0);
    wait_rsp(b + 2);
    check("b2b_spacing", acc_edges[a + 1] - acc_edges[a], 5);
    check("b2b_after_ack", acc_edges[a + 1] > hs_edges[b], 1'b1);
    check("b2b_rdata", got_data[b + 1], 8'h3C);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_port_ctrl.md
# ram_port_ctrl

Synchronous initiator for the 16×8 `Ram` block. It accepts single-beat write requests and burst read requests over a valid/ready request channel. It drives the `Ram` read and write pins, generating a clean, isolated `write_enable` strobe, and returns read data and write acknowledgements over a valid/ready response channel. It sits between the core's load/store path and the `Ram` instance.

## Interface
Parameters:
- `AW`, 4: RAM address width; depth is 2^AW, and addresses wrap modulo 2^AW.
- `DW`, 8: RAM data width.

Ports:
- Clocking is fixed: one clock, and reset is synchronous and active-low.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept a request; equals (state==IDLE).
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  AW  start address.
- `req_wdata`  in  DW  write data; ignored for reads.
- `req_len`  in  AW  read beats minus 1 (0..15); ignored for writes.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_rdata`  out  DW  read data; 0 for write acknowledgements.
- `rsp_last`  out  1  final beat of the request.
- `rsp_is_write`  out  1  response is a write acknowledgement.
- `ram_addr_read`  out  AW  to `Ram.addr_read`.
- `ram_read_enable`  out  1  to `Ram.read_enable`.
- `ram_data_out`  in  DW  from `Ram.data_out` (combinational read).
- `ram_data_in`  out  DW  to `Ram.data_in`.
- `ram_addr_write`  out  AW  to `Ram.addr_write`.
- `ram_write_enable`  out  1  to `Ram.write_enable`; the RAM writes on its rising edge.

## Operation
- States: IDLE, WR_SETUP, WR_STROBE, WR_HOLD, WR_ACK, RD_ISSUE, RD_RSP.
- All outputs other than `req_ready` are registered.
- **Accept:** a request is accepted when `req_valid && req_ready` at a clock edge. The controller latches `req_we`, `req_addr`, `req_wdata` and `req_len`, and clears the beat counter.
- **Write sequence:**
  - IDLE → WR_SETUP: drive `ram_addr_write` and `ram_data_in`; `ram_write_enable` = 0.
  - WR_SETUP → WR_STROBE: `ram_write_enable` = 1 for exactly one cycle.
  - WR_STROBE → WR_HOLD: `ram_write_enable` = 0; address and data are held unchanged.
  - WR_HOLD → WR_ACK: `rsp_valid` = 1, `rsp_is_write` = 1, `rsp_last` = 1, `rsp_rdata` = 0.
  - WR_ACK → IDLE on `rsp_ready`.
- **Read sequence:**
  - RD_ISSUE: `ram_read_enable` = 1, `ram_addr_read` = current address.
  - At the next edge, capture `ram_data_out` into `rsp_rdata` and go to RD_RSP. Set `rsp_valid` = 1, `rsp_is_write` = 0, `rsp_last` = (beat == len). `ram_read_enable` = 0 in RD_RSP.
  - RD_RSP on `rsp_ready`: if last, go to IDLE. Otherwise address = (address + 1) mod 2^AW, beat + 1, and go to RD_ISSUE.
- Address arithmetic is AW bits: 4'hF + 1 = 4'h0. A burst of 16 beats starting at any address visits every location once.
- Response hold: while `rsp_valid` = 1 and `rsp_ready` = 0, all `rsp_*` outputs are stable.
- Ordering: only one request is outstanding. A new request is not accepted until the final response handshake completes.
- Reset (`rst_n` = 0 at an edge):
  - State → IDLE.
  - `rsp_valid`, `rsp_rdata`, `rsp_last`, `rsp_is_write`, `ram_read_enable`, `ram_write_enable`, `ram_addr_read`, `ram_addr_write` and `ram_data_in` all → 0.
  - `req_ready` reads 1 from the first cycle after reset.
  - A request presented on the same edge as an active reset is not accepted.
- Reset mid-operation: the transaction is abandoned and no response is issued.
  - If reset lands in WR_STROBE, `ram_write_enable` falls at that edge. The RAM location may hold the new data.
  - If reset lands before WR_STROBE, the RAM is untouched.

## Timing
- Write, accept at edge N:
  - `ram_write_enable` is high between edges N+1 and N+2.
  - `rsp_valid` rises after edge N+3.
  - Minimum accept-to-accept spacing is 5 cycles.
- Write signal timing: address and data are stable for ≥1 full cycle before the `ram_write_enable` rising edge and ≥1 full cycle after its falling edge.
- Read, accept at edge N:
  - `ram_read_enable` is high in the cycle after N.
  - `rsp_valid` rises after edge N+1.
- Read beat throughput: 2 cycles per beat with `rsp_ready` tied high. A burst of L+1 beats takes 2(L+1) cycles from accept to the last handshake.
- `rsp_ready` is sampled only while `rsp_valid` = 1.

## Test plan
- **Reset defaults:**
  - Stimulus: hold `rst_n` = 0 for 3 cycles with `req_valid` = 1.
  - Response: all outputs are 0, no request is accepted, and `req_ready` = 1 after release.
- **Write then read:**
  - Stimulus: write 8'hA5 to address 3, then read with `len` = 0.
  - Response: `ram_write_enable` pulses once, with `addr_write` = 3 and `data_in` = A5 stable on both sides of the pulse. The ack has `rsp_is_write` = 1. The read returns `rdata` = A5 with `rsp_last` = 1, 2 cycles after accept.
- **Wrap burst:**
  - Stimulus: preload mem[i] = i + 8'h10, then read from address 14 with `len` = 3.
  - Response: beats 1E, 1F, 10, 11 are returned, and `rsp_last` is asserted only on 11.
- **Backpressure:**
  - Stimulus: during the same burst, hold `rsp_ready` = 0 for 4 cycles on beat 2.
  - Response: `rsp_rdata` = 1F and `rsp_valid` stay stable, `ram_read_enable` stays 0, and `req_ready` = 0 throughout.
- **Reset mid-write:**
  - Stimulus: assert `rst_n` = 0 at the WR_SETUP → WR_STROBE edge.
  - Response: `ram_write_enable` never rises, the target location is unchanged, and no response is issued.
- **Back-to-back requests:**
  - Stimulus: hold `req_valid` high with a write to address 0 followed by a read of address 0.
  - Response: the second request is accepted only after the write-ack handshake, and the read returns the written value.
